// File: rtl/dly_mon_pkg.sv
// Shared definitions for the dlya delay-chain measurement blocks.
package dly_mon_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } mon_state_t;

  // Default widths and timing
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WIN_W       = 16;
  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Fewer flops than this do not give adequate metastability protection
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/dly_ring_sync.sv
// Synchroniser for an asynchronous delay-chain tap, with a one-cycle
// pulse on every synchronised rising edge.
module dly_ring_sync
  import dly_mon_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rn,
  input  logic async_in,
  output logic rise
);

  // Depth is never allowed below the safe minimum
  localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] sync_reg;
  logic         prev_reg;

  // Shift the tap through the synchroniser and remember the last synchronised level
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[N-2:0], async_in};
      prev_reg <= sync_reg[N-1];
    end
  end

  assign rise = sync_reg[N-1] & ~prev_reg;

endmodule

// File: rtl/dly_ring_monitor.sv
// Ring-oscillator frequency monitor: enables the ring, lets it settle,
// counts its rising edges over a window of CLK cycles and reports the count.
module dly_ring_monitor
  import dly_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RING_IN,
  output logic             RING_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  // Down-counter must hold both the settle length and the window length
  localparam int DW = (WIN_W > 8) ? WIN_W : 8;

  mon_state_t       state_reg, state_next;
  logic [DW-1:0]    dcnt_reg, dcnt_next;
  logic [WIN_W-1:0] win_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             accept;
  logic             done_c;
  logic             ring_rise;

  dly_ring_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (CLK),
    .rn       (RN),
    .async_in (RING_IN),
    .rise     (ring_rise)
  );

  // ABORT outranks START even while idle
  assign accept = (state_reg == IDLE) && START && !ABORT;

  // State register and settle/window down-counter
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  // Next-state logic; the down-counter reloads on each phase change
  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SETTLE;
          dcnt_next  = DW'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (ABORT) begin
          state_next = IDLE;
        end else if (dcnt_reg == '0) begin
          if (win_reg == '0) begin
            state_next = REPORT;
          end else begin
            state_next = MEASURE;
            dcnt_next  = DW'(win_reg) - DW'(1);
          end
        end else begin
          dcnt_next = dcnt_reg - DW'(1);
        end
      end
      MEASURE: begin
        if (ABORT) begin
          state_next = IDLE;
        end else if (dcnt_reg == '0) begin
          state_next = REPORT;
        end else begin
          dcnt_next = dcnt_reg - DW'(1);
        end
      end
      REPORT: begin
        state_next = IDLE;
        done_c     = !ABORT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window capture and saturating edge counter with sticky overflow
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      win_reg <= '0;
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else if (accept) begin
      win_reg <= WINDOW;
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else if (state_reg == MEASURE && ring_rise) begin
      if (cnt_reg == {CNT_W{1'b1}}) begin
        sat_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Result registers hold the last completed measurement
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (done_c) begin
      count_reg <= cnt_reg;
      ovf_reg   <= sat_reg;
    end
  end

  // The new result is already visible during the DONE cycle; an ABORT there keeps the old one
  assign COUNT   = done_c ? cnt_reg : count_reg;
  assign OVF     = done_c ? sat_reg : ovf_reg;
  assign DONE    = done_c;
  assign BUSY    = (state_reg != IDLE);
  assign RING_EN = (state_reg == SETTLE) || (state_reg == MEASURE);

endmodule

// File: tb/tb_dly_ring_monitor.sv
// Directed bench for dly_ring_monitor: a default-width instance and a
// 4-bit counter instance share the clock, reset, window and ring tap.
module tb_dly_ring_monitor;

  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rn;
  logic        start_a, start_b, abort_a, abort_b;
  logic [15:0] window;
  logic        ring_in;
  logic        ring_en_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        ring_en_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int tests  = 0;
  int failed = 0;
  int ring_half = 0;
  int ring_cnt  = 0;

  typedef struct {
    int sel;
    int win;
    int half;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  vec_t vecs[8];

  dly_ring_monitor #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .RN(rn), .START(start_a), .ABORT(abort_a), .WINDOW(window),
    .RING_IN(ring_in), .RING_EN(ring_en_a), .BUSY(busy_a), .DONE(done_a),
    .COUNT(count_a), .OVF(ovf_a)
  );

  dly_ring_monitor #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) dut_b (
    .CLK(clk), .RN(rn), .START(start_b), .ABORT(abort_b), .WINDOW(window),
    .RING_IN(ring_in), .RING_EN(ring_en_b), .BUSY(busy_b), .DONE(done_b),
    .COUNT(count_b), .OVF(ovf_b)
  );

  always #5 clk = ~clk;

  // Free-running ring model: level held ring_half cycles, stopped when ring_half is 0
  always @(negedge clk) begin
    if (ring_half > 0) begin
      ring_cnt = ring_cnt + 1;
      if (ring_cnt >= ring_half) begin
        ring_cnt = 0;
        ring_in  = ~ring_in;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue START now and advance until DONE (bounded); lat counts cycles from START
  task automatic run_meas(input int sel, input int w, output int lat, output int cnt, output int ovf);
    window = 16'(w);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    while (!done_of(sel) && lat < 2000) begin
      step();
      lat++;
    end
    if (!done_of(sel)) lat = -1;
    cnt = (sel == 0) ? int'(count_a) : int'(count_b);
    ovf = (sel == 0) ? int'(ovf_a) : int'(ovf_b);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done_a) n++;
    end
  endtask

  initial begin
    int lat, cnt, ovf, n;

    vecs[0] = '{0, 100, 5, 10, 0};
    vecs[1] = '{0,   0, 2,  0, 0};
    vecs[2] = '{0,  40, 2, 10, 0};
    vecs[3] = '{0,  60, 3, 10, 0};
    vecs[4] = '{0,  30, 0,  0, 0};
    vecs[5] = '{1, 200, 3, 15, 1};
    vecs[6] = '{1,  30, 3,  5, 0};
    vecs[7] = '{0, 100, 5, 10, 0};

    rn = 1'b0; start_a = 0; start_b = 0; abort_a = 0; abort_b = 0;
    window = '0; ring_in = 1'b0;
    repeat (3) step();
    check("reset_ring_en", int'(ring_en_a), 0);
    check("reset_busy",    int'(busy_a),    0);
    check("reset_done",    int'(done_a),    0);
    check("reset_count",   int'(count_a),   0);
    check("reset_ovf",     int'(ovf_a),     0);
    @(negedge clk);
    rn = 1'b1;
    step();

    // Table-driven measurements
    for (int v = 0; v < 8; v++) begin
      ring_half = vecs[v].half;
      repeat (20) step();
      run_meas(vecs[v].sel, vecs[v].win, lat, cnt, ovf);
      $display("[TB] vec %0d dut=%0d win=%0d half=%0d lat=%0d count=%0d ovf=%0d",
               v, vecs[v].sel, vecs[v].win, vecs[v].half, lat, cnt, ovf);
      check($sformatf("vec%0d_latency", v), lat, 1 + SETTLE + vecs[v].win);
      check($sformatf("vec%0d_count", v),   cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_ovf", v),     ovf, vecs[v].exp_ovf);
      step();
      check($sformatf("vec%0d_done_pulse", v), int'(done_of(vecs[v].sel)), 0);
      check($sformatf("vec%0d_busy_after", v), int'((vecs[v].sel == 0) ? busy_a : busy_b), 0);
    end

    // ABORT at cycle 50 of MEASURE
    ring_half = 5;
    window  = 16'd100;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (57) step();
    abort_a = 1'b1;
    check("abort_in_measure_ring_en", int'(ring_en_a), 1);
    step();
    abort_a = 1'b0;
    check("abort_ring_en_next", int'(ring_en_a), 0);
    check("abort_busy_next",    int'(busy_a),    0);
    count_dones(120, n);
    check("abort_no_done",   n, 0);
    check("abort_count_kept", int'(count_a), 10);
    $display("[TB] abort mid-measure: dones=%0d count=%0d", n, count_a);
    run_meas(0, 20, lat, cnt, ovf);
    $display("[TB] after abort win=20 lat=%0d count=%0d", lat, cnt);
    check("post_abort_latency", lat, 1 + SETTLE + 20);
    check("post_abort_count",   cnt, 2);
    step();

    // ABORT in the REPORT cycle suppresses DONE and keeps the old result
    repeat (5) step();
    run_meas(0, 10, lat, cnt, ovf);
    abort_a = 1'b1;
    #1;
    check("abort_report_done",  int'(done_a),  0);
    check("abort_report_count", int'(count_a), 2);
    step();
    abort_a = 1'b0;
    check("abort_report_busy",       int'(busy_a),  0);
    check("abort_report_count_held", int'(count_a), 2);
    $display("[TB] abort in report: count=%0d", count_a);

    // START and ABORT together in IDLE
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_idle_busy", int'(busy_a), 0);
    $display("[TB] start+abort in idle: busy=%0d", busy_a);

    // Back-to-back: START while busy and in REPORT ignored, first IDLE cycle accepted
    repeat (5) step();
    window  = 16'd20;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    lat = 1;
    repeat (4) begin step(); lat++; end
    start_a = 1'b1;
    step();
    lat++;
    start_a = 1'b0;
    while (!done_a && lat < 2000) begin step(); lat++; end
    check("b2b_first_latency", lat, 1 + SETTLE + 20);
    check("b2b_first_count",   int'(count_a), 2);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("b2b_report_start_ignored", int'(busy_a), 0);
    run_meas(0, 20, lat, cnt, ovf);
    $display("[TB] back-to-back second: lat=%0d count=%0d", lat, cnt);
    check("b2b_second_latency", lat, 1 + SETTLE + 20);
    check("b2b_second_count",   cnt, 2);
    step();

    // Asynchronous reset mid-MEASURE with the ring running
    window  = 16'd100;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (40) step();
    #2;
    rn = 1'b0;
    #1;
    check("midreset_ring_en", int'(ring_en_a), 0);
    check("midreset_busy",    int'(busy_a),    0);
    check("midreset_done",    int'(done_a),    0);
    check("midreset_count",   int'(count_a),   0);
    check("midreset_ovf",     int'(ovf_a),     0);
    @(negedge clk);
    rn = 1'b1;
    step();
    count_dones(150, n);
    check("midreset_no_done", n, 0);
    check("midreset_idle",    int'(busy_a), 0);
    $display("[TB] mid-measure reset: dones=%0d busy=%0d", n, busy_a);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
